// File: rtl/thread_fetch_unit.sv
// -----------------------------------------------------------------------------
// thread_fetch_unit
//
// Per-thread instruction fetch stage for the interleaved multithreaded core.
// Keeps one program counter per hardware thread, issues an instruction-memory
// read for the thread picked by the round-robin selector, and hands the
// returned word to decode tagged with its thread ID and PC. Control-flow
// redirects from execute overwrite a thread's PC, suppress a same-cycle fetch
// of that thread and squash its in-flight (wrong-path) instruction.
//
// Parameters
//   THREAD_POOL_SIZE  number of hardware threads (1..4)
//   XLEN              PC / instruction width
//   RESET_PC          boot PC of thread 0
//   THREAD_PC_STRIDE  boot-PC spacing between consecutive threads
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous, active-high reset
//   TID_fetch       thread selected for fetch this cycle
//   thread_active   per-thread run enable (0 = halted)
//   redirect_valid  control-flow change request
//   redirect_tid    thread being redirected
//   redirect_pc     new PC for redirect_tid
//   imem_req        instruction read request this cycle
//   imem_addr       read address, pc[TID_fetch]
//   imem_rdata      read data, one cycle after imem_req
//   if_id_valid     delivered instruction is live
//   if_id_tid       thread of the delivered instruction
//   if_id_pc        PC of the delivered instruction
//   if_id_instr     delivered instruction word
// -----------------------------------------------------------------------------
module thread_fetch_unit #(
  parameter int unsigned     THREAD_POOL_SIZE = 4,
  parameter int unsigned     XLEN             = 32,
  parameter logic [XLEN-1:0] RESET_PC         = '0,
  parameter logic [XLEN-1:0] THREAD_PC_STRIDE = XLEN'(32'h0000_1000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      TID_fetch,
  input  logic [3:0]      thread_active,
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_tid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [1:0]      if_id_tid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr
);

  // Thread count widened by one bit so that a pool of 4 is representable and
  // a plain unsigned compare tells in-range thread IDs apart.
  localparam logic [2:0] POOL_SIZE = 3'(THREAD_POOL_SIZE);

  function automatic logic [XLEN-1:0] boot_pc(input int unsigned t);
    return RESET_PC + XLEN'(t) * THREAD_PC_STRIDE;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] pc      [THREAD_POOL_SIZE];
  logic [XLEN-1:0] pc_next [THREAD_POOL_SIZE];

  logic            s1_valid;
  logic [1:0]      s1_tid;
  logic [XLEN-1:0] s1_pc;

  // ---------------------------------------------------------------------------
  // Fetch qualification and issue
  // ---------------------------------------------------------------------------
  logic            fetch_tid_in_range;
  logic            redirect_tid_in_range;
  logic            redirect_hits_fetch;
  logic            fetch_ok;
  logic [XLEN-1:0] fetch_pc;

  assign fetch_tid_in_range    = ({1'b0, TID_fetch} < POOL_SIZE);
  assign redirect_tid_in_range = ({1'b0, redirect_tid} < POOL_SIZE);

  // A redirect aimed at the thread being fetched wins: the old-path fetch is
  // dropped and the thread picks up the new PC at its next selector slot.
  assign redirect_hits_fetch = redirect_valid && (redirect_tid == TID_fetch);

  assign fetch_ok = fetch_tid_in_range && thread_active[TID_fetch] && !redirect_hits_fetch;

  // Explicit mux rather than pc[TID_fetch] so an out-of-range selector never
  // indexes past the end of a reduced thread pool; the address is don't-care
  // in that case and simply reads as zero.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise an unassigned path infers a latch.
  always_comb begin
    fetch_pc = '0;
    for (int t = 0; t < int'(THREAD_POOL_SIZE); t++) begin
      if (TID_fetch == 2'(t)) fetch_pc = pc[t];
    end
  end

  assign imem_req  = fetch_ok;
  assign imem_addr = fetch_pc;

  // ---------------------------------------------------------------------------
  // Per-thread PC next-state: redirect > own fetch (+4, wraps) > hold.
  // Redirects and fetches of different threads are independent.
  // Out-of-range redirect IDs never match a thread index, so they are ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int t = 0; t < int'(THREAD_POOL_SIZE); t++) begin
      pc_next[t] = pc[t];
      if (redirect_valid && redirect_tid_in_range && (redirect_tid == 2'(t))) begin
        pc_next[t] = redirect_pc;
      end else if (fetch_ok && (TID_fetch == 2'(t))) begin
        pc_next[t] = pc[t] + XLEN'(4);
      end
    end
  end

  // NOTE: the PC file is reset element by element because every thread has a
  // distinct architectural boot PC; storage without a defined reset value
  // would be left out of the reset branch.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < int'(THREAD_POOL_SIZE); t++) begin
        pc[t] <= boot_pc(t);
      end
    end else begin
      for (int t = 0; t < int'(THREAD_POOL_SIZE); t++) begin
        pc[t] <= pc_next[t];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request stage: tracks the read that is in flight in the memory. Tag and
  // PC are captured even for bubbles; only s1_valid qualifies them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tid   <= '0;
      s1_pc    <= '0;
    end else begin
      s1_valid <= fetch_ok;
      s1_tid   <= TID_fetch;
      s1_pc    <= imem_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Delivery to decode. A redirect arriving while the instruction is in flight
  // means it was fetched down the wrong path, so it is squashed here. Halting
  // a thread does not squash: only redirects kill in-flight work.
  // ---------------------------------------------------------------------------
  assign if_id_valid = s1_valid && !(redirect_valid && (redirect_tid == s1_tid));
  assign if_id_tid   = s1_tid;
  assign if_id_pc    = s1_pc;
  assign if_id_instr = imem_rdata;

endmodule

// File: tb/tb_thread_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_thread_fetch_unit
//
// Directed, table-driven bench for thread_fetch_unit with default parameters
// (4 threads, XLEN=32, boot PCs 0x0/0x1000/0x2000/0x3000). Each table row is
// one clock cycle of stimulus plus the hand-computed outputs expected during
// that cycle. A one-cycle memory model returns instr_of(addr) for the address
// presented at each rising edge. Reset behaviour is covered by hand-written
// sequences before and after the table.
// -----------------------------------------------------------------------------
module tb_thread_fetch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  TID_fetch;
  logic [3:0]  thread_active;
  logic        redirect_valid;
  logic [1:0]  redirect_tid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [1:0]  if_id_tid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int checks   = 0;
  int failures = 0;

  thread_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .TID_fetch      (TID_fetch),
    .thread_active  (thread_active),
    .redirect_valid (redirect_valid),
    .redirect_tid   (redirect_tid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_tid      (if_id_tid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  tid;
    logic [3:0]  act;
    logic        rv;
    logic [1:0]  rtid;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [1:0]  exp_tid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] tid, input logic [3:0] act,
                              input logic rv, input logic [1:0] rtid,
                              input logic [31:0] rpc, input logic exp_req,
                              input logic [31:0] exp_addr, input logic exp_valid,
                              input logic [1:0] exp_tid, input logic [31:0] exp_pc);
    vec_t v;
    v.tid = tid; v.act = act; v.rv = rv; v.rtid = rtid; v.rpc = rpc;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_valid = exp_valid;
    v.exp_tid = exp_tid; v.exp_pc = exp_pc;
    return v;
  endfunction

  // Instruction word the memory model stores at a given address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Apply one row: drive inputs just after an edge, check mid-cycle, then
  // clock it and let the memory model answer the request presented at the edge.
  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] addr_at_edge;
    TID_fetch      = v.tid;
    thread_active  = v.act;
    redirect_valid = v.rv;
    redirect_tid   = v.rtid;
    redirect_pc    = v.rpc;
    #3;
    check($sformatf("c%0d imem_req", idx), 32'(imem_req), 32'(v.exp_req));
    check($sformatf("c%0d imem_addr", idx), imem_addr, v.exp_addr);
    check($sformatf("c%0d if_id_valid", idx), 32'(if_id_valid), 32'(v.exp_valid));
    if (v.exp_valid) begin
      check($sformatf("c%0d if_id_tid", idx), 32'(if_id_tid), 32'(v.exp_tid));
      check($sformatf("c%0d if_id_pc", idx), if_id_pc, v.exp_pc);
      check($sformatf("c%0d if_id_instr", idx), if_id_instr, instr_of(v.exp_pc));
    end
    addr_at_edge = imem_addr;
    @(posedge clk);
    #1;
    imem_rdata = instr_of(addr_at_edge);
  endtask

  initial begin
    vec_t post[$];

    rst            = 1'b1;
    TID_fetch      = 2'd2;
    thread_active  = 4'hF;
    redirect_valid = 1'b0;
    redirect_tid   = 2'd0;
    redirect_pc    = 32'h0;
    imem_rdata     = 32'h0;

    // Boot (0-4), in-flight squash of thread 1 then non-squash via thread 3
    // (5-11), redirect while fetching thread 2 (12-18), simultaneous redirect
    // of thread 0 with fetch of thread 3 (19-23), halt of thread 1 including
    // a non-squashed in-flight fetch (24-31), PC wrap on thread 0 (32-35).
    vecs.push_back(mk(0, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0000, 0, 0, 32'h0));
    vecs.push_back(mk(1, 4'hF, 0, 0, 32'h0,         1, 32'h0000_1000, 1, 0, 32'h0000_0000));
    vecs.push_back(mk(2, 4'hF, 0, 0, 32'h0,         1, 32'h0000_2000, 1, 1, 32'h0000_1000));
    vecs.push_back(mk(3, 4'hF, 0, 0, 32'h0,         1, 32'h0000_3000, 1, 2, 32'h0000_2000));
    vecs.push_back(mk(0, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 3, 32'h0000_3000));
    vecs.push_back(mk(1, 4'hF, 0, 0, 32'h0,         1, 32'h0000_1004, 1, 0, 32'h0000_0004));
    vecs.push_back(mk(2, 4'hF, 1, 1, 32'h40,        1, 32'h0000_2004, 0, 0, 32'h0));
    vecs.push_back(mk(3, 4'hF, 0, 0, 32'h0,         1, 32'h0000_3004, 1, 2, 32'h0000_2004));
    vecs.push_back(mk(0, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0008, 1, 3, 32'h0000_3004));
    vecs.push_back(mk(1, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0040, 1, 0, 32'h0000_0008));
    vecs.push_back(mk(2, 4'hF, 1, 3, 32'h300,       1, 32'h0000_2008, 1, 1, 32'h0000_0040));
    vecs.push_back(mk(3, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0300, 1, 2, 32'h0000_2008));
    vecs.push_back(mk(0, 4'hF, 0, 0, 32'h0,         1, 32'h0000_000C, 1, 3, 32'h0000_0300));
    vecs.push_back(mk(1, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0044, 1, 0, 32'h0000_000C));
    vecs.push_back(mk(2, 4'hF, 1, 2, 32'h800,       0, 32'h0000_200C, 1, 1, 32'h0000_0044));
    vecs.push_back(mk(3, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0304, 0, 0, 32'h0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0010, 1, 3, 32'h0000_0304));
    vecs.push_back(mk(1, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0048, 1, 0, 32'h0000_0010));
    vecs.push_back(mk(2, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0800, 1, 1, 32'h0000_0048));
    vecs.push_back(mk(3, 4'hF, 1, 0, 32'h100,       1, 32'h0000_0308, 1, 2, 32'h0000_0800));
    vecs.push_back(mk(0, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0100, 1, 3, 32'h0000_0308));
    vecs.push_back(mk(1, 4'hF, 0, 0, 32'h0,         1, 32'h0000_004C, 1, 0, 32'h0000_0100));
    vecs.push_back(mk(2, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0804, 1, 1, 32'h0000_004C));
    vecs.push_back(mk(3, 4'hF, 0, 0, 32'h0,         1, 32'h0000_030C, 1, 2, 32'h0000_0804));
    vecs.push_back(mk(0, 4'hD, 0, 0, 32'h0,         1, 32'h0000_0104, 1, 3, 32'h0000_030C));
    vecs.push_back(mk(1, 4'hD, 0, 0, 32'h0,         0, 32'h0000_0050, 1, 0, 32'h0000_0104));
    vecs.push_back(mk(2, 4'hD, 0, 0, 32'h0,         1, 32'h0000_0808, 0, 0, 32'h0));
    vecs.push_back(mk(3, 4'hD, 0, 0, 32'h0,         1, 32'h0000_0310, 1, 2, 32'h0000_0808));
    vecs.push_back(mk(0, 4'hD, 0, 0, 32'h0,         1, 32'h0000_0108, 1, 3, 32'h0000_0310));
    vecs.push_back(mk(1, 4'hD, 0, 0, 32'h0,         0, 32'h0000_0050, 1, 0, 32'h0000_0108));
    vecs.push_back(mk(1, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0050, 0, 0, 32'h0));
    vecs.push_back(mk(2, 4'hD, 0, 0, 32'h0,         1, 32'h0000_080C, 1, 1, 32'h0000_0050));
    vecs.push_back(mk(0, 4'hF, 1, 0, 32'hFFFF_FFFC, 0, 32'h0000_010C, 1, 2, 32'h0000_080C));
    vecs.push_back(mk(0, 4'hF, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 32'h0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 0, 32'hFFFF_FFFC));
    vecs.push_back(mk(3, 4'hF, 0, 0, 32'h0,         1, 32'h0000_0314, 1, 0, 32'h0000_0000));

    // Reset state while rst is held.
    #2;
    check("rst if_id_valid", 32'(if_id_valid), 32'h0);
    check("rst if_id_tid", 32'(if_id_tid), 32'h0);
    check("rst if_id_pc", if_id_pc, 32'h0);
    check("rst imem_addr t2", imem_addr, 32'h0000_2000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Asynchronous reset in the middle of a valid delivery (thread 3 @ 0x314).
    TID_fetch     = 2'd1;
    thread_active = 4'hF;
    #2;
    check("pre-rst if_id_valid", 32'(if_id_valid), 32'h1);
    check("pre-rst if_id_pc", if_id_pc, 32'h0000_0314);
    rst = 1'b1;
    #1;
    check("async rst if_id_valid", 32'(if_id_valid), 32'h0);
    check("async rst if_id_pc", if_id_pc, 32'h0);
    check("async rst if_id_tid", 32'(if_id_tid), 32'h0);
    check("async rst pc1", imem_addr, 32'h0000_1000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First requests after deassertion use boot PCs.
    post.push_back(mk(0, 4'hF, 0, 0, 32'h0, 1, 32'h0000_0000, 0, 0, 32'h0));
    post.push_back(mk(3, 4'hF, 0, 0, 32'h0, 1, 32'h0000_3000, 1, 0, 32'h0000_0000));
    post.push_back(mk(2, 4'hF, 0, 0, 32'h0, 1, 32'h0000_2000, 1, 3, 32'h0000_3000));
    post.push_back(mk(0, 4'hF, 0, 0, 32'h0, 1, 32'h0000_0004, 1, 2, 32'h0000_2000));
    foreach (post[i]) run_vec(post[i], 100 + i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/thread_fetch_unit.md
# thread_fetch_unit

Per-thread instruction fetch stage of the interleaved multithreaded core. It sits directly downstream of the round-robin thread selector and consumes its `TID_fetch` each cycle. It holds one program counter per hardware thread and issues an instruction-memory read for the selected thread. It delivers the returned instruction, tagged with thread ID and PC, to decode. It also applies per-thread control-flow redirects from the execute stage and squashes stale in-flight fetches.

## Interface
- `THREAD_POOL_SIZE`, default 4: number of hardware threads; range 1..4.
- `XLEN`, default 32: PC and instruction width.
- `RESET_PC`, default 32'h0000_0000: boot PC of thread 0.
- `THREAD_PC_STRIDE`, default 32'h0000_1000: boot-PC spacing between threads.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `TID_fetch`  in  2  thread selected for fetch this cycle.
- `thread_active`  in  4  per-thread run enable; bit t=0 halts thread t.
- `redirect_valid`  in  1  control-flow change request.
- `redirect_tid`  in  2  thread being redirected.
- `redirect_pc`  in  XLEN  new PC for `redirect_tid`.
- `imem_req`  out  1  instruction read request this cycle.
- `imem_addr`  out  XLEN  read address, equal to `pc[TID_fetch]`.
- `imem_rdata`  in  XLEN  read data, valid the cycle after `imem_req`; synchronous memory with 1-cycle latency and no backpressure.
- `if_id_valid`  out  1  the instruction on `if_id_instr` is live.
- `if_id_tid`  out  2  thread of the delivered instruction.
- `if_id_pc`  out  XLEN  PC of the delivered instruction.
- `if_id_instr`  out  XLEN  instruction word, equal to `imem_rdata`.

## Operation
- **State**
  - `pc[0..THREAD_POOL_SIZE-1]`, XLEN each.
  - Request-stage register `s1_valid`, `s1_tid`, `s1_pc`.
- **Fetch qualify:** `fetch_ok = (TID_fetch < THREAD_POOL_SIZE) & thread_active[TID_fetch] & ~(redirect_valid & redirect_tid == TID_fetch)`.
- **Issue:** `imem_req = fetch_ok`. `imem_addr = pc[TID_fetch]`. When `TID_fetch` is out of range, the address is don't-care.
- **PC update per thread t, with priority:**
  1. If `redirect_valid & redirect_tid == t`, then `pc[t] <= redirect_pc`.
  2. Else if `fetch_ok & TID_fetch == t`, then `pc[t] <= pc[t] + 4`, modulo 2^XLEN (wrap from all-ones-minus-3 to 0).
  3. Else hold.
- **Redirect to a fetching thread:** the fetch is suppressed and the thread is not re-fetched until its next selector slot.
- **Independent threads:** a redirect to one thread and a fetch of another in the same cycle both take effect.
- **Out-of-range redirect:** `redirect_tid >= THREAD_POOL_SIZE` is ignored.
- **Request stage:** on every edge, `s1_valid <= fetch_ok`, `s1_tid <= TID_fetch`, `s1_pc <= imem_addr`.
- **Delivery**
  - `if_id_tid = s1_tid`; `if_id_pc = s1_pc`; `if_id_instr = imem_rdata`.
  - `if_id_valid = s1_valid & ~(redirect_valid & redirect_tid == s1_tid)`. This squashes a wrong-path instruction that is already in flight.
- **Halt:** a thread with `thread_active=0` produces a bubble in its slot and its PC holds. Clearing the bit does not squash that thread's in-flight fetch.

## Timing
- **Reset (async, immediate)**
  - `pc[t] = RESET_PC + t*THREAD_PC_STRIDE`.
  - `s1_valid=0`, `s1_tid=0`, `s1_pc=0`.
  - Hence `if_id_valid=0`, `if_id_tid=0`, `if_id_pc=0`.
  - `imem_req` and `imem_addr` are combinational from reset state and inputs.
- **Latency:** a request in cycle N appears on `if_id_*` in cycle N+1. Throughput is one fetch per cycle.
- **Sustained round-robin:** each thread fetches every THREAD_POOL_SIZE cycles. Its PC advances by 4 per own slot.
- **Reset mid-operation:** the in-flight fetch is lost and all PCs return to boot values. The first request after deassertion uses boot PCs.
- **No decode stall input:** decode must accept one instruction per cycle.

## Test plan
- **Boot:** reset, then release with selector order 0,1,2,3,0, all active. Expect `imem_addr` = 0x0, 0x1000, 0x2000, 0x3000, 0x4. Each `if_id_pc` and `if_id_tid` appears one cycle later with `if_id_valid=1`.
- **Redirect while fetching:** `TID_fetch=2` with `redirect_valid=1`, `redirect_tid=2`, `redirect_pc=0x800`. Expect `imem_req=0` and the next cycle `if_id_valid=0`. Thread 2's next slot fetches 0x800.
- **In-flight squash:** thread 1 fetched at 0x1004 in cycle N. In cycle N+1, redirect `tid=1` to 0x40. Expect `if_id_valid=0` in N+1 and thread 1 next fetches 0x40. Repeat with the redirect targeting thread 3 instead: expect `if_id_valid=1`.
- **Simultaneous events:** redirect of thread 0 to 0x100 while thread 3 fetches. Expect `pc[0]=0x100` and `pc[3]` advanced by 4.
- **Halt and wrap:** set `thread_active=4'b1101` and confirm thread 1 slots give bubbles and its PC holds. Then redirect thread 0 to 0xFFFF_FFFC and fetch it twice: addresses 0xFFFF_FFFC, then 0x0.
- **Async reset:** assert `rst` mid-cycle during a valid delivery. Expect `if_id_valid` to drop immediately and PCs to return to boot values.
